// File: rtl/multiplier_datapath_taint_track_word.sv
// multiplier_datapath_taint_track_word
// Datapath half of a sequential shift-add multiplier with word-level taint.
// Holds the multiplicand (mdReg), the multiplier (mrReg, never shifted) and
// the running sum (rsReg, 2*WIDTH+1 bits; the top bit is the adder carry).
// Running-sum command priority: rsclear > rsload > rsshr.
// Optional build macro DP_CTRL_TAINT_EN: when defined, the taint of each
// control strobe also propagates into the taint of the register it drives.
module multiplier_datapath_taint_track_word #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic               multiplicand_t,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic               multiplier_t,
  input  logic               rsload,
  input  logic               rsclear,
  input  logic               rsshr,
  input  logic               mrld,
  input  logic               mdld,
  input  logic               rsload_t,
  input  logic               rsclear_t,
  input  logic               rsshr_t,
  input  logic               mrld_t,
  input  logic               mdld_t,
  output logic [WIDTH-1:0]   multiplierReg,
  output logic               multiplierReg_t,
  output logic [2*WIDTH-1:0] product,
  output logic               product_t
);

  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0] md_q, md_d;
  logic             md_t_q, md_t_d;
  logic [WIDTH-1:0] mr_q, mr_d;
  logic             mr_t_q, mr_t_d;
  logic [PW:0]      rs_q, rs_d;
  logic             rs_t_q, rs_t_d;
  logic [WIDTH:0]   rs_sum;

  // Upper half plus multiplicand; the carry lands in bit 2W of the sum.
  assign rs_sum = {1'b0, rs_q[PW-1:WIDTH]} + {1'b0, md_q};

`ifdef DP_CTRL_TAINT_EN
  logic mdld_e, mrld_e, rsclear_e, rsload_e, rsshr_e;
  assign mdld_e    = mdld | mdld_t;
  assign mrld_e    = mrld | mrld_t;
  assign rsclear_e = rsclear | rsclear_t;
  assign rsload_e  = rsload | rsload_t;
  assign rsshr_e   = rsshr | rsshr_t;
`else
  // Strobe taints have no effect in this build.
  logic unused_strobe_t;
  assign unused_strobe_t = ^{rsload_t, rsclear_t, rsshr_t, mrld_t, mdld_t};
`endif

  // Next-state for data and taint; data always follows the plain strobes.
  always_comb begin
    md_d   = md_q;
    md_t_d = md_t_q;
    mr_d   = mr_q;
    mr_t_d = mr_t_q;
    rs_d   = rs_q;
    rs_t_d = rs_t_q;

    if (mdld) md_d = multiplicand;
    if (mrld) mr_d = multiplier;

    if (rsclear)     rs_d = '0;
    else if (rsload) rs_d[PW:WIDTH] = rs_sum;
    else if (rsshr)  rs_d = {1'b0, rs_q[PW:1]};

`ifdef DP_CTRL_TAINT_EN
    if (mdld_e) md_t_d = multiplicand_t | mdld_t;
    if (mrld_e) mr_t_d = multiplier_t | mrld_t;

    if (rsclear_e)     rs_t_d = rsclear_t;
    else if (rsload_e) rs_t_d = rs_t_q | md_t_q | rsload_t;
    else if (rsshr_e)  rs_t_d = rs_t_q | rsshr_t;
`else
    if (mdld) md_t_d = multiplicand_t;
    if (mrld) mr_t_d = multiplier_t;

    if (rsclear)     rs_t_d = 1'b0;
    else if (rsload) rs_t_d = rs_t_q | md_t_q;
`endif
  end

  // State registers; synchronous reset overrides any command in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_q   <= '0;
      md_t_q <= 1'b0;
      mr_q   <= '0;
      mr_t_q <= 1'b0;
      rs_q   <= '0;
      rs_t_q <= 1'b0;
    end else begin
      md_q   <= md_d;
      md_t_q <= md_t_d;
      mr_q   <= mr_d;
      mr_t_q <= mr_t_d;
      rs_q   <= rs_d;
      rs_t_q <= rs_t_d;
    end
  end

  assign multiplierReg   = mr_q;
  assign multiplierReg_t = mr_t_q;
  assign product         = rs_q[PW-1:0];
  assign product_t       = rs_t_q;

endmodule

// File: tb/tb_multiplier_datapath_taint_track_word.sv
// Bench for multiplier_datapath_taint_track_word: integer-arithmetic model
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_multiplier_datapath_taint_track_word;

  localparam int W  = 4;
  localparam int PW = 2 * W;

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] multiplicand, multiplier;
  logic multiplicand_t, multiplier_t;
  logic rsload, rsclear, rsshr, mrld, mdld;
  logic rsload_t, rsclear_t, rsshr_t, mrld_t, mdld_t;
  logic [W-1:0]  multiplierReg;
  logic          multiplierReg_t;
  logic [PW-1:0] product;
  logic          product_t;

  int checks = 0;
  int errors = 0;

  // Model state as plain integers
  int m_md, m_mr, m_rs;
  int m_md_t, m_mr_t, m_rs_t;
  int n_md, n_mr, n_rs, n_md_t, n_mr_t, n_rs_t;
  int hi, lo;
  bit chk_en = 1'b0;

  int saw_nz;
  int first_load_t;

  multiplier_datapath_taint_track_word #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .multiplicand(multiplicand), .multiplicand_t(multiplicand_t),
    .multiplier(multiplier), .multiplier_t(multiplier_t),
    .rsload(rsload), .rsclear(rsclear), .rsshr(rsshr), .mrld(mrld), .mdld(mdld),
    .rsload_t(rsload_t), .rsclear_t(rsclear_t), .rsshr_t(rsshr_t),
    .mrld_t(mrld_t), .mdld_t(mdld_t),
    .multiplierReg(multiplierReg), .multiplierReg_t(multiplierReg_t),
    .product(product), .product_t(product_t)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Behavioural model: running sum as an integer value
  always @(posedge clk) begin
    if (rst) begin
      m_md = 0; m_mr = 0; m_rs = 0;
      m_md_t = 0; m_mr_t = 0; m_rs_t = 0;
    end else begin
      n_md = mdld ? int'(multiplicand) : m_md;
      n_mr = mrld ? int'(multiplier) : m_mr;
      lo = m_rs % (2 ** W);
      hi = (m_rs / (2 ** W)) % (2 ** W);
      if (rsclear)     n_rs = 0;
      else if (rsload) n_rs = lo + (hi + m_md) * (2 ** W);
      else if (rsshr)  n_rs = m_rs / 2;
      else             n_rs = m_rs;
`ifdef DP_CTRL_TAINT_EN
      n_md_t = (mdld || mdld_t) ? int'(multiplicand_t || mdld_t) : m_md_t;
      n_mr_t = (mrld || mrld_t) ? int'(multiplier_t || mrld_t) : m_mr_t;
      if (rsclear || rsclear_t)    n_rs_t = int'(rsclear_t);
      else if (rsload || rsload_t) n_rs_t = int'((m_rs_t != 0) || (m_md_t != 0) || rsload_t);
      else if (rsshr || rsshr_t)   n_rs_t = int'((m_rs_t != 0) || rsshr_t);
      else                         n_rs_t = m_rs_t;
`else
      n_md_t = mdld ? int'(multiplicand_t) : m_md_t;
      n_mr_t = mrld ? int'(multiplier_t) : m_mr_t;
      if (rsclear)     n_rs_t = 0;
      else if (rsload) n_rs_t = int'((m_rs_t != 0) || (m_md_t != 0));
      else             n_rs_t = m_rs_t;
`endif
      m_md = n_md; m_mr = n_mr; m_rs = n_rs;
      m_md_t = n_md_t; m_mr_t = n_mr_t; m_rs_t = n_rs_t;
    end
  end

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_multiplierReg",   int'(multiplierReg),   m_mr);
      check("cyc_multiplierReg_t", int'(multiplierReg_t), m_mr_t);
      check("cyc_product",         int'(product),         m_rs % (2 ** PW));
      check("cyc_product_t",       int'(product_t),       m_rs_t);
    end
  end

  task automatic step(input bit c, input bit l, input bit s, input bit mr, input bit md);
    rsclear = c; rsload = l; rsshr = s; mrld = mr; mdld = md;
    @(negedge clk);
    rsclear = 0; rsload = 0; rsshr = 0; mrld = 0; mdld = 0;
  endtask

  task automatic multiply(input int a, input int b, input bit at, input bit bt);
    logic [W-1:0] bv;
    bv = W'(b);
    multiplicand = W'(a); multiplicand_t = at;
    multiplier   = W'(b); multiplier_t   = bt;
    saw_nz = 0;
    first_load_t = -1;
    step(1, 0, 0, 1, 1);
    if (product != 0) saw_nz = 1;
    for (int i = 0; i < W; i++) begin
      step(0, 0, 1, 0, 0);
      if (product != 0) saw_nz = 1;
      if (bv[i]) begin
        step(0, 1, 0, 0, 0);
        if (first_load_t < 0) first_load_t = int'(product_t);
      end else begin
        step(0, 0, 0, 0, 0);
      end
      if (product != 0) saw_nz = 1;
    end
    step(0, 0, 1, 0, 0);
    if (product != 0) saw_nz = 1;
  endtask

  initial begin
    rst = 1;
    multiplicand = 0; multiplicand_t = 0; multiplier = 0; multiplier_t = 0;
    rsload = 0; rsclear = 0; rsshr = 0; mrld = 0; mdld = 0;
    rsload_t = 0; rsclear_t = 0; rsshr_t = 0; mrld_t = 0; mdld_t = 0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1;
    check("reset_multiplierReg",   int'(multiplierReg),   0);
    check("reset_multiplierReg_t", int'(multiplierReg_t), 0);
    check("reset_product",         int'(product),         0);
    check("reset_product_t",       int'(product_t),       0);
    rst = 0;

    multiply(5, 3, 0, 0);
    check("5x3_product",       int'(product),       15);
    check("5x3_product_t",     int'(product_t),     0);
    check("5x3_multiplierReg", int'(multiplierReg), 3);

    multiply(15, 15, 0, 0);
    check("15x15_product", int'(product), 225);

    multiply(0, 9, 0, 0);
    check("0x9_product",    int'(product), 0);
    check("0x9_never_nz",   saw_nz,        0);

    multiply(6, 5, 1, 0);
    check("6x5_mdt_first_load_t", first_load_t,          1);
    check("6x5_mdt_product",       int'(product),         30);
    check("6x5_mdt_product_t",     int'(product_t),       1);
    check("6x5_mdt_mrReg_t",       int'(multiplierReg_t), 0);

    multiply(6, 5, 0, 1);
    check("6x5_mrt_product",   int'(product),         30);
    check("6x5_mrt_product_t", int'(product_t),       0);
    check("6x5_mrt_mrReg_t",   int'(multiplierReg_t), 1);

    // Build rsReg = 0x2A, then clear and load together
    multiplicand = 10; multiplicand_t = 0; multiplier_t = 0;
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    multiplicand = 2;
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    check("setup_0x2A", int'(product), 42);
    step(1, 1, 0, 0, 0);
    check("clear_over_load", int'(product), 0);

    // Reset in the middle of a multiply, with commands asserted alongside
    multiplicand = 7; multiplicand_t = 1; multiplier = 7; multiplier_t = 1;
    step(1, 0, 0, 1, 1);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    check("pre_rst_product", int'(product), 112);
    rst = 1; rsload = 1; mrld = 1; mdld = 1;
    @(negedge clk);
    rst = 0; rsload = 0; mrld = 0; mdld = 0;
    check("rst_multiplierReg",   int'(multiplierReg),   0);
    check("rst_multiplierReg_t", int'(multiplierReg_t), 0);
    check("rst_product",         int'(product),         0);
    check("rst_product_t",       int'(product_t),       0);
    multiplicand_t = 0; multiplier_t = 0;

    // Tainted rsload strobe with the plain strobe low
    multiply(5, 3, 0, 0);
    rsload_t = 1;
    step(0, 0, 0, 0, 0);
    rsload_t = 0;
    check("rsload_t_product", int'(product), 15);
`ifdef DP_CTRL_TAINT_EN
    check("rsload_t_product_t", int'(product_t), 1);
`else
    check("rsload_t_product_t", int'(product_t), 0);
`endif

    step(0, 0, 0, 0, 0);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplier_datapath_taint_track_word.md
# multiplier_datapath_taint_track_word

Datapath half of the sequential shift-add multiplier with word-level taint tracking. It executes the control strobes `rsload`, `rsclear`, `rsshr`, `mrld` and `mdld` issued by the multiplier control FSM, each with its taint shadow. It returns the stored multiplier word and its taint to the controller for the per-bit branch decision. It also holds the running sum and presents the final product with a single word taint bit.

## Interface
- `WIDTH`, 4: operand width in bits; product is 2*WIDTH bits.
- `clk` input 1: clock; all state updates on posedge.
- `rst` input 1: reset. One clock; reset is synchronous and active-high.
- `multiplicand` input WIDTH: operand loaded by `mdld`.
- `multiplicand_t` input 1: taint of `multiplicand`.
- `multiplier` input WIDTH: operand loaded by `mrld`.
- `multiplier_t` input 1: taint of `multiplier`.
- `rsload`, `rsclear`, `rsshr`, `mrld`, `mdld` input 1 each: control strobes from the controller.
- `rsload_t`, `rsclear_t`, `rsshr_t`, `mrld_t`, `mdld_t` input 1 each: taint of each strobe.
- `multiplierReg` output WIDTH: stored multiplier, returned to the controller.
- `multiplierReg_t` output 1: taint of `multiplierReg`.
- `product` output 2*WIDTH: running sum bits [2W-1:0].
- `product_t` output 1: taint of the running sum.

## Operation
- Internal registers: `mdReg` (WIDTH) with taint `mdReg_t`; `mrReg` (WIDTH, drives `multiplierReg`) with taint `mrReg_t`; `rsReg` (2*WIDTH+1, bit 2W is the adder carry) with taint `rsReg_t`.
- `mdld`: `mdReg` takes `multiplicand`; `mdReg_t` takes `multiplicand_t`.
- `mrld`: `mrReg` takes `multiplier`; `mrReg_t` takes `multiplier_t`.
- `mrReg` is never shifted. The controller indexes it by its own bit counter.
- Running-sum command priority when several are asserted together: `rsclear` over `rsload` over `rsshr`. Only one action is applied per cycle.
  - `rsclear`: `rsReg` becomes 0; `rsReg_t` becomes 0.
  - `rsload`: `rsReg[2W:W]` becomes `rsReg[2W-1:W]` + `mdReg`, a (WIDTH+1)-bit sum. Low half is unchanged. `rsReg_t` becomes `rsReg_t | mdReg_t`.
  - `rsshr`: `rsReg` shifts right by 1 with 0 filled into bit 2W. `rsReg_t` is unchanged.
- `mdld` and `mrld` are independent of each other and of the running-sum commands. They may coincide with `rsclear`, which is the INIT cycle.
- Expected command sequence from the controller:
  - INIT: `mdld`, `mrld` and `rsclear` together.
  - Per bit i: one `rsshr` cycle, then either an `rsload` cycle (when multiplier bit i is 1) or an idle NOP cycle.
  - FINAL: one `rsshr`.
- The first `rsshr` acts on zero and is harmless. The net effect is W add-then-shift steps, leaving the exact product in `rsReg[2W-1:0]`.
- Word-level taint only: no per-bit taint. Branch taint on the multiplier bit is the controller's job.

## Timing
- Every command is sampled at a posedge and takes effect at that edge. Results are visible on outputs in the following cycle.
- `multiplierReg` is valid the cycle after `mrld`, which is in time for the SHIFT state that follows INIT.
- `product` is final the cycle after the FINAL `rsshr`. It holds until the next `rsclear` or `rst`.
- Reset values: all registers 0 and all taint bits 0. So `multiplierReg`=0, `multiplierReg_t`=0, `product`=0, `product_t`=0.
- Reset mid-operation: everything clears on that edge. Any command asserted in the same cycle is ignored.
- Carry bit 2W may be 1 transiently after `rsload`. It is shifted into bit 2W-1 by the next `rsshr`. No overflow is possible for WIDTH-bit operands.

## Configuration
- `DP_CTRL_TAINT_EN` defined: control-strobe taints propagate. Each register treats its strobe as asserted-for-taint when `strobe | strobe_t` is 1:
  - `mdld` path: `mdReg_t` becomes `multiplicand_t | mdld_t`.
  - `mrld` path: `mrReg_t` becomes `multiplier_t | mrld_t`.
  - `rsclear` path: `rsReg_t` becomes `rsclear_t`.
  - `rsload` path: `rsReg_t` becomes `rsReg_t | mdReg_t | rsload_t`.
  - `rsshr` path: `rsReg_t` becomes `rsReg_t | rsshr_t`.
  - Data values still follow the plain strobes only.
- `DP_CTRL_TAINT_EN` undefined: all `*_t` strobe inputs are ignored and taint follows the data rules in Operation.

## Test plan
- WIDTH=4, multiplicand=5, multiplier=3, full controller sequence -> `product`=15, `product_t`=0, `multiplierReg`=3.
- 15 x 15 -> `product`=225, with the carry path exercised. 0 x 9 -> `product`=0, `rsReg` never nonzero.
- `multiplicand_t`=1, 6 x 5 -> `product_t` goes to 1 on the first `rsload` and stays 1; `product`=30. Same operands with `multiplier_t`=1 -> `multiplierReg_t`=1, `product_t`=0.
- `rsclear` and `rsload` asserted in the same cycle with `rsReg`=0x2A -> `rsReg`=0. `rst` asserted mid-multiply -> all outputs 0 next cycle.
- With `DP_CTRL_TAINT_EN`, all-clean data and `rsload`=0, `rsload_t`=1 for one cycle -> `product_t`=1 and `product` unchanged. Without the macro -> `product_t`=0.
